// File: rtl/lzw_code_packer.sv
// lzw_code_packer: packs fixed-width LZW codes MSB-first into a byte stream.
// Codes enter over a valid/ready handshake into a left-aligned bit
// accumulator. Whole bytes are peeled off the top into a one-deep output
// register that has its own valid/ready handshake. A flush pulse drains
// the remaining bits, zero-pads the last byte and pulses flush_done.
// Optional feature macro: PACK_BYTE_CNT_EN adds a 24-bit byte_count output.
module lzw_code_packer #(
    parameter int CODE_W = 13,
    localparam int ACC_W = CODE_W + 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic              flush,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              flush_done,
    output logic              busy
`ifdef PACK_BYTE_CNT_EN
    ,
    output logic [23:0]       byte_count
`endif
);

    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [4:0]       cnt;
    logic [4:0]       cnt_next;
    logic [ACC_W-1:0] code_ext;
    logic             accept;
    logic             out_free;
    logic             extract;

    // Zero-extended code; shifting it left by (7 - cnt) lands it just
    // below the bits already held in the accumulator.
    assign code_ext   = {{(ACC_W-CODE_W){1'b0}}, code_in};

    assign code_ready = (state == RUN) && (cnt < 5'd8);
    assign accept     = code_valid && code_ready;
    assign out_free   = !byte_valid || byte_ready;

    // A full byte can leave whenever the output register is free; while
    // flushing, a partial byte may leave too (its low bits are already 0).
    assign extract    = out_free &&
                        ((cnt >= 5'd8) || ((state == FLUSH) && (cnt != 5'd0)));

    assign flush_done = (state == DONE);
    assign busy       = (cnt != 5'd0) || byte_valid || (state != RUN);

    // Next-state logic for the flush sequencer and the bit accumulator.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;

        if (accept) begin
            acc_next = acc | (code_ext << (3'd7 - cnt[2:0]));
            cnt_next = cnt + 5'(CODE_W);
        end else if (extract) begin
            acc_next = acc << 8;
            cnt_next = (cnt >= 5'd8) ? (cnt - 5'd8) : 5'd0;
        end

        case (state)
            RUN: begin
                if (flush) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if ((cnt == 5'd0) && !byte_valid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                acc_next   = '0;
                cnt_next   = 5'd0;
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // State, accumulator and bit-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            acc   <= '0;
            cnt   <= 5'd0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
        end
    end

    // Output byte register: loads on extract, otherwise empties on ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
        end else if (extract) begin
            byte_out   <= acc[ACC_W-1 -: 8];
            byte_valid <= 1'b1;
        end else if (byte_ready) begin
            byte_valid <= 1'b0;
        end
    end

`ifdef PACK_BYTE_CNT_EN
    // Counts delivered bytes; restarts after each completed flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_count <= 24'd0;
        end else if (state == DONE) begin
            byte_count <= 24'd0;
        end else if (byte_valid && byte_ready) begin
            byte_count <= byte_count + 24'd1;
        end
    end
`endif

endmodule
